// File: rtl/nmea_pkg.sv
// Shared constants, parser state encoding and character helpers for the
// RMC sentence parser.
package nmea_pkg;

    localparam logic [7:0] CH_DOLLAR = 8'h24;
    localparam logic [7:0] CH_COMMA  = 8'h2C;
    localparam logic [7:0] CH_STAR   = 8'h2A;
    localparam logic [7:0] CH_DOT    = 8'h2E;
    localparam logic [7:0] CH_CR     = 8'h0D;
    localparam logic [7:0] CH_LF     = 8'h0A;
    localparam logic [7:0] CH_A      = 8'h41;
    localparam logic [7:0] CH_N      = 8'h4E;
    localparam logic [7:0] CH_E      = 8'h45;
    localparam logic [7:0] CH_R      = 8'h52;
    localparam logic [7:0] CH_M      = 8'h4D;
    localparam logic [7:0] CH_C      = 8'h43;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_FIELD,
        ST_CK_HI,
        ST_CK_LO
    } state_t;

    function automatic logic is_digit(input logic [7:0] c);
        return (c >= 8'h30) && (c <= 8'h39);
    endfunction

    // Returns {valid, nibble}; accepts 0-9, A-F and a-f.
    function automatic logic [4:0] hex_nibble(input logic [7:0] c);
        if (is_digit(c)) begin
            return {1'b1, c[3:0]};
        end
        if (((c >= 8'h41) && (c <= 8'h46)) || ((c >= 8'h61) && (c <= 8'h66))) begin
            return {1'b1, c[3:0] + 4'd9};
        end
        return 5'b0_0000;
    endfunction

endpackage

// File: rtl/nmea_num_accum.sv
// Accumulates one "d..dmm.f..." coordinate field into integer degrees and
// minutes scaled by 10^FRAC_DIGITS, using shift-add arithmetic only.
module nmea_num_accum
    import nmea_pkg::*;
#(
    parameter int INT_DIGITS  = 2,
    parameter int FRAC_DIGITS = 4,
    parameter int MIN_W       = 20
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             digit_stb,
    input  logic [3:0]       digit,
    input  logic             dot_stb,
    input  logic             finalise,
    output logic [7:0]       deg,
    output logic [MIN_W-1:0] minutes,
    output logic             has_data,
    output logic             bad
);

    localparam int FW = (FRAC_DIGITS < 1) ? 1 : $clog2(FRAC_DIGITS + 1);
    localparam logic [FW-1:0] FRAC_MAX = FW'(FRAC_DIGITS);
    localparam logic [3:0] DEG_END = 4'(INT_DIGITS);
    localparam logic [3:0] MIN_END = 4'(INT_DIGITS + 2);
    localparam int unsigned FRAC_N = FRAC_DIGITS;

    logic [7:0]       deg_acc;
    logic [MIN_W-1:0] min_acc;
    logic [3:0]       int_cnt;
    logic [FW-1:0]    frac_cnt;
    logic             in_frac;
    logic             closed;
    logic [11:0]      deg_next;

    function automatic logic [MIN_W-1:0] times10(input logic [MIN_W-1:0] v);
        return (v << 3) + (v << 1);
    endfunction

    // Next degree value, wide enough to detect an 8-bit overflow.
    always_comb begin
        deg_next = ({4'b0, deg_acc} << 3) + ({4'b0, deg_acc} << 1) + {8'b0, digit};
    end

    // Digit/dot accumulation; a finalised field ignores further strobes.
    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            deg_acc  <= '0;
            min_acc  <= '0;
            int_cnt  <= '0;
            frac_cnt <= '0;
            in_frac  <= 1'b0;
            closed   <= 1'b0;
            has_data <= 1'b0;
            bad      <= 1'b0;
        end else if (!closed) begin
            if (digit_stb) begin
                has_data <= 1'b1;
                if (!in_frac) begin
                    if (int_cnt < DEG_END) begin
                        deg_acc <= deg_next[7:0];
                        if (deg_next[11:8] != 4'd0) begin
                            bad <= 1'b1;
                        end
                    end else if (int_cnt < MIN_END) begin
                        min_acc <= times10(min_acc) + MIN_W'(digit);
                    end else begin
                        bad <= 1'b1;
                    end
                    if (int_cnt != 4'hF) begin
                        int_cnt <= int_cnt + 4'd1;
                    end
                end else if (frac_cnt < FRAC_MAX) begin
                    min_acc  <= times10(min_acc) + MIN_W'(digit);
                    frac_cnt <= frac_cnt + FW'(1);
                end
            end
            if (dot_stb) begin
                if (in_frac) begin
                    bad <= 1'b1;
                end else begin
                    in_frac <= 1'b1;
                end
            end
            if (finalise) begin
                closed <= 1'b1;
            end
        end
    end

    // Missing fractional digits are padded combinationally from the held
    // value, so a commit on the byte that ends the field already sees the
    // fully scaled minutes.
    always_comb begin
        minutes = min_acc;
        for (int unsigned i = 0; i < FRAC_N; i++) begin
            if (i >= 32'(frac_cnt)) begin
                minutes = times10(minutes);
            end
        end
    end

    assign deg = deg_acc;

endmodule

// File: rtl/nmea_rmc_parser.sv
// Byte-serial NMEA RMC parser: address match, field decode, XOR checksum
// and atomic commit of the position/status record.
module nmea_rmc_parser
    import nmea_pkg::*;
#(
    parameter int FRAC_DIGITS = 4,
    parameter int MIN_W       = 20,
    parameter int MAX_LINE    = 82,
    parameter bit CHECK_EN    = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             fix_strobe,
    output logic             gps_valid,
    output logic             north,
    output logic             east,
    output logic [7:0]       lat_deg,
    output logic [MIN_W-1:0] lat_min,
    output logic [7:0]       lon_deg,
    output logic [MIN_W-1:0] lon_min,
    output logic             cksum_err,
    output logic             fmt_err
);

    localparam int LCW = $clog2(MAX_LINE + 1);
    localparam logic [LCW-1:0] LINE_MAX = LCW'(MAX_LINE);

    state_t           state;
    logic [7:0]       xor_acc;
    logic [7:0]       ck_val;
    logic [LCW-1:0]   line_cnt;
    logic [LCW-1:0]   line_next;
    logic [3:0]       field_idx;
    logic [2:0]       addr_cnt;
    logic             sent_bad;
    logic             ck_full;
    logic             sh_valid;
    logic             sh_north;
    logic             sh_east;

    logic             is_dollar;
    logic             is_term;
    logic             field_byte;
    logic             field_end;
    logic [4:0]       hn;
    logic             bad_any;
    logic             acc_clear;
    logic             lat_digit, lat_dot, lat_fin;
    logic             lon_digit, lon_dot, lon_fin;

    logic [7:0]       lat_deg_v, lon_deg_v;
    logic [MIN_W-1:0] lat_min_v, lon_min_v;
    logic             lat_has, lon_has, lat_bad, lon_bad;

    // Byte classification and accumulator strobes for the current byte.
    always_comb begin
        is_dollar  = (in_data == CH_DOLLAR);
        is_term    = (in_data == CH_CR) || (in_data == CH_LF);
        line_next  = line_cnt + LCW'(1);
        hn         = hex_nibble(in_data);
        bad_any    = sent_bad | lat_bad | lon_bad;
        acc_clear  = in_valid && is_dollar;
        field_byte = in_valid && !is_dollar && (state == ST_FIELD);
        field_end  = is_term || (in_data == CH_COMMA) || (in_data == CH_STAR);
        lat_digit  = field_byte && (field_idx == 4'd3) && is_digit(in_data);
        lat_dot    = field_byte && (field_idx == 4'd3) && (in_data == CH_DOT);
        lat_fin    = field_byte && (field_idx == 4'd3) && field_end;
        lon_digit  = field_byte && (field_idx == 4'd5) && is_digit(in_data);
        lon_dot    = field_byte && (field_idx == 4'd5) && (in_data == CH_DOT);
        lon_fin    = field_byte && (field_idx == 4'd5) && field_end;
    end

    nmea_num_accum #(
        .INT_DIGITS (2),
        .FRAC_DIGITS(FRAC_DIGITS),
        .MIN_W      (MIN_W)
    ) u_lat (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear    (acc_clear),
        .digit_stb(lat_digit),
        .digit    (in_data[3:0]),
        .dot_stb  (lat_dot),
        .finalise (lat_fin),
        .deg      (lat_deg_v),
        .minutes  (lat_min_v),
        .has_data (lat_has),
        .bad      (lat_bad)
    );

    nmea_num_accum #(
        .INT_DIGITS (3),
        .FRAC_DIGITS(FRAC_DIGITS),
        .MIN_W      (MIN_W)
    ) u_lon (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear    (acc_clear),
        .digit_stb(lon_digit),
        .digit    (in_data[3:0]),
        .dot_stb  (lon_dot),
        .finalise (lon_fin),
        .deg      (lon_deg_v),
        .minutes  (lon_min_v),
        .has_data (lon_has),
        .bad      (lon_bad)
    );

    // Sentence FSM with registered record outputs and one-cycle status pulses.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            xor_acc    <= '0;
            ck_val     <= '0;
            line_cnt   <= '0;
            field_idx  <= '0;
            addr_cnt   <= '0;
            sent_bad   <= 1'b0;
            ck_full    <= 1'b0;
            sh_valid   <= 1'b0;
            sh_north   <= 1'b0;
            sh_east    <= 1'b0;
            fix_strobe <= 1'b0;
            cksum_err  <= 1'b0;
            fmt_err    <= 1'b0;
            gps_valid  <= 1'b0;
            north      <= 1'b0;
            east       <= 1'b0;
            lat_deg    <= '0;
            lat_min    <= '0;
            lon_deg    <= '0;
            lon_min    <= '0;
        end else begin
            fix_strobe <= 1'b0;
            cksum_err  <= 1'b0;
            fmt_err    <= 1'b0;
            if (in_valid) begin
                if (is_dollar) begin
                    state     <= ST_ADDR;
                    xor_acc   <= '0;
                    ck_val    <= '0;
                    line_cnt  <= LCW'(1);
                    field_idx <= '0;
                    addr_cnt  <= '0;
                    sent_bad  <= 1'b0;
                    ck_full   <= 1'b0;
                    sh_valid  <= 1'b0;
                    sh_north  <= 1'b0;
                    sh_east   <= 1'b0;
                end else if (state != ST_IDLE) begin
                    line_cnt <= line_next;
                    if (is_term) begin
                        state <= ST_IDLE;
                        if ((state == ST_FIELD) || ((state == ST_CK_LO) && ck_full)) begin
                            if (bad_any) begin
                                fmt_err <= 1'b1;
                            end else if ((state == ST_FIELD) ? CHECK_EN : (ck_val != xor_acc)) begin
                                cksum_err <= 1'b1;
                            end else begin
                                fix_strobe <= 1'b1;
                                gps_valid  <= sh_valid;
                                north      <= sh_north;
                                east       <= sh_east;
                                if (lat_has) begin
                                    lat_deg <= lat_deg_v;
                                    lat_min <= lat_min_v;
                                end
                                if (lon_has) begin
                                    lon_deg <= lon_deg_v;
                                    lon_min <= lon_min_v;
                                end
                            end
                        end else if (state != ST_ADDR) begin
                            fmt_err <= 1'b1;
                        end
                    end else if (line_next >= LINE_MAX) begin
                        state   <= ST_IDLE;
                        fmt_err <= 1'b1;
                    end else begin
                        unique case (state)
                            ST_ADDR: begin
                                xor_acc  <= xor_acc ^ in_data;
                                addr_cnt <= addr_cnt + 3'd1;
                                if (addr_cnt == 3'd5) begin
                                    if (in_data == CH_COMMA) begin
                                        state     <= ST_FIELD;
                                        field_idx <= 4'd1;
                                    end else begin
                                        state <= ST_IDLE;
                                    end
                                end else if (((addr_cnt == 3'd2) && (in_data != CH_R)) ||
                                             ((addr_cnt == 3'd3) && (in_data != CH_M)) ||
                                             ((addr_cnt == 3'd4) && (in_data != CH_C))) begin
                                    state <= ST_IDLE;
                                end
                            end
                            ST_FIELD: begin
                                if (in_data == CH_STAR) begin
                                    state <= ST_CK_HI;
                                end else begin
                                    xor_acc <= xor_acc ^ in_data;
                                    if (in_data == CH_COMMA) begin
                                        if (field_idx != 4'hF) begin
                                            field_idx <= field_idx + 4'd1;
                                        end
                                    end else begin
                                        case (field_idx)
                                            4'd2: sh_valid <= (in_data == CH_A);
                                            4'd4: sh_north <= (in_data == CH_N);
                                            4'd6: sh_east  <= (in_data == CH_E);
                                            4'd3, 4'd5: begin
                                                if (!is_digit(in_data) && (in_data != CH_DOT)) begin
                                                    sent_bad <= 1'b1;
                                                end
                                            end
                                            default: ;
                                        endcase
                                    end
                                end
                            end
                            ST_CK_HI: begin
                                ck_val[7:4] <= hn[3:0];
                                if (!hn[4]) begin
                                    sent_bad <= 1'b1;
                                end
                                state <= ST_CK_LO;
                            end
                            ST_CK_LO: begin
                                if (!ck_full) begin
                                    ck_val[3:0] <= hn[3:0];
                                    ck_full     <= 1'b1;
                                    if (!hn[4]) begin
                                        sent_bad <= 1'b1;
                                    end
                                end else begin
                                    sent_bad <= 1'b1;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_nmea_rmc_parser.sv
// Directed bench for the RMC parser: hand-computed records and pulse counts.
module tb_nmea_rmc_parser;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        fix_strobe, gps_valid, north, east, cksum_err, fmt_err;
    logic [7:0]  lat_deg, lon_deg;
    logic [19:0] lat_min, lon_min;

    int n_checks = 0;
    int n_errors = 0;
    int n_fix = 0;
    int n_ck  = 0;
    int n_fmt = 0;
    bit gap   = 1'b0;

    localparam string S1 = "$GPRMC,123519,A,4807.038,N,01131.000,E,022.4,084.4,230394,003.1,W";
    localparam string S3 = "$GNRMC,081836,V,3355.12345,S,15112.5,W,000.0,360.0,130998,011.3,E";

    nmea_rmc_parser #(
        .FRAC_DIGITS(4),
        .MIN_W      (20),
        .MAX_LINE   (82),
        .CHECK_EN   (1'b1)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .fix_strobe(fix_strobe),
        .gps_valid (gps_valid),
        .north     (north),
        .east      (east),
        .lat_deg   (lat_deg),
        .lat_min   (lat_min),
        .lon_deg   (lon_deg),
        .lon_min   (lon_min),
        .cksum_err (cksum_err),
        .fmt_err   (fmt_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (fix_strobe === 1'b1) n_fix++;
        if (cksum_err === 1'b1)  n_ck++;
        if (fmt_err === 1'b1)    n_fmt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic string with_ck(input string body, input bit lower);
        logic [7:0] x;
        x = '0;
        for (int i = 1; i < body.len(); i++) x ^= body[i];
        if (lower) return $sformatf("%s*%02x", body, x);
        return $sformatf("%s*%02X", body, x);
    endfunction

    task automatic send_byte(input logic [7:0] b);
        if (gap) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic run(input string tag, input string s, input bit term,
                       input int e_fix, input int e_ck, input int e_fmt);
        int f0, c0, m0;
        f0 = n_fix; c0 = n_ck; m0 = n_fmt;
        send_str(s);
        if (term) begin
            send_byte(8'h0D);
            send_byte(8'h0A);
        end
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_eq({tag, "_fix"}, n_fix - f0, e_fix);
        check_eq({tag, "_cksum"}, n_ck - c0, e_ck);
        check_eq({tag, "_fmt"}, n_fmt - m0, e_fmt);
    endtask

    task automatic check_record(input string tag, input logic v, input logic n, input logic e,
                                input int ld, input int lm, input int od, input int om);
        check_eq({tag, "_gps_valid"}, gps_valid, v);
        check_eq({tag, "_north"}, north, n);
        check_eq({tag, "_east"}, east, e);
        check_eq({tag, "_lat_deg"}, lat_deg, ld);
        check_eq({tag, "_lat_min"}, lat_min, lm);
        check_eq({tag, "_lon_deg"}, lon_deg, od);
        check_eq({tag, "_lon_min"}, lon_min, om);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        string line;
        int f0, c0, m0;
        reset_n  = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(negedge clk);
        check_eq("rst_fix", fix_strobe, 0);
        check_eq("rst_cksum", cksum_err, 0);
        check_eq("rst_fmt", fmt_err, 0);
        check_record("rst", 0, 0, 0, 0, 0, 0, 0);
        reset_n = 1'b1;

        // Classic sentence, with commit latency checked on the cycle after CR.
        f0 = n_fix; c0 = n_ck; m0 = n_fmt;
        send_str({S1, "*6A"});
        send_byte(8'h0D);
        @(negedge clk);
        check_eq("t1_latency_fix", fix_strobe, 1);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_eq("t1_fix", n_fix - f0, 1);
        check_eq("t1_cksum", n_ck - c0, 0);
        check_eq("t1_fmt", n_fmt - m0, 0);
        check_record("t1", 1, 1, 1, 48, 70380, 11, 310000);

        run("t2", {S1, "*6B"}, 1'b1, 0, 1, 0);
        check_record("t2", 1, 1, 1, 48, 70380, 11, 310000);

        gap = 1'b1;
        run("t3", with_ck(S3, 1'b0), 1'b1, 1, 0, 0);
        check_record("t3", 0, 0, 0, 33, 551234, 151, 125000);
        gap = 1'b0;

        run("gga", with_ck("$GPGGA,123519,4807.038,N,01131.000,E,1,08,0.9,545.4,M,46.9,M,,", 1'b0),
            1'b1, 0, 0, 0);
        check_eq("gga_lat_deg", lat_deg, 33);
        check_eq("gga_lat_min", lat_min, 551234);

        run("lower", with_ck(S1, 1'b1), 1'b1, 1, 0, 0);
        check_eq("lower_lat_deg", lat_deg, 48);
        check_eq("lower_lon_min", lon_min, 310000);

        run("restart", {"$GPRMC,123519,A,48", with_ck(S3, 1'b0)}, 1'b1, 1, 0, 0);
        check_eq("restart_lat_deg", lat_deg, 33);
        check_eq("restart_gps_valid", gps_valid, 0);

        run("nostar", S1, 1'b1, 0, 1, 0);
        check_eq("nostar_lat_deg", lat_deg, 33);

        run("badchar",
            with_ck("$GPRMC,123519,A,48A7.038,N,01131.000,E,022.4,084.4,230394,003.1,W", 1'b0),
            1'b1, 0, 0, 1);
        check_eq("badchar_lat_deg", lat_deg, 33);

        run("empty", with_ck("$GPRMC,123519,A,,,,,022.4,084.4,230394,003.1,W", 1'b0),
            1'b1, 1, 0, 0);
        check_record("empty", 1, 0, 0, 33, 551234, 151, 125000);

        // 90-byte line with no terminator: error must fire on byte 82.
        line = "$GPRMC,";
        for (int i = 0; i < 83; i++) line = {line, "1"};
        f0 = n_fix; c0 = n_ck; m0 = n_fmt;
        for (int i = 0; i < 82; i++) send_byte(line[i]);
        @(negedge clk);
        check_eq("long_at_82", fmt_err, 1);
        for (int i = 82; i < line.len(); i++) send_byte(line[i]);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_eq("long_fmt", n_fmt - m0, 1);
        check_eq("long_fix", n_fix - f0, 0);
        check_eq("long_cksum", n_ck - c0, 0);

        // Reset in the middle of the longitude field.
        send_str("$GPRMC,123519,A,4807.038,N,011");
        @(negedge clk);
        in_valid = 1'b0;
        reset_n  = 1'b0;
        repeat (2) @(negedge clk);
        check_record("midrst", 0, 0, 0, 0, 0, 0, 0);
        reset_n = 1'b1;
        run("postrst", {S1, "*6A"}, 1'b1, 1, 0, 0);
        check_record("postrst", 1, 1, 1, 48, 70380, 11, 310000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/nmea_rmc_parser.md
Name: nmea_rmc_parser

Overview:
- Clocked, parametrised successor to the GPS NMEA decoder.
- Consumes an ASCII byte stream from the UART receiver, one byte per `in_valid` strobe in the `clk` domain.
- Parses RMC sentences from any talker (`$GP`, `$GN`, `$GL`, …) and verifies the NMEA XOR checksum.
- Publishes an atomically updated position/status record only for sentences that are well-formed and pass the checksum.

Parameters:
- `FRAC_DIGITS`, 4: number of fractional-minute digits kept; minutes are output as minutes × 10^FRAC_DIGITS.
- `MIN_W`, 20: width of the minutes outputs; must hold 59 × 10^FRAC_DIGITS + (10^FRAC_DIGITS − 1).
- `MAX_LINE`, 82: maximum number of bytes from `$` to `<CR>` inclusive; a longer line is aborted.
- `CHECK_EN`, 1: 1 means checksum is mandatory; 0 means a sentence with no `*` field is accepted.

Ports:
- `clk`  in  1  system clock.
- `reset_n`  in  1  synchronous, active-low reset.
- `in_valid`  in  1  byte strobe, one cycle per byte; may be asserted every cycle.
- `in_data`  in  8  ASCII byte, sampled when `in_valid` = 1.
- `fix_strobe`  out  1  one-cycle pulse when the output record updates.
- `gps_valid`  out  1  status field = `A`.
- `north`  out  1  hemisphere field = `N`.
- `east`  out  1  hemisphere field = `E`.
- `lat_deg`  out  8  latitude degrees, 0..90.
- `lat_min`  out  `MIN_W`  latitude minutes, scaled.
- `lon_deg`  out  8  longitude degrees, 0..180.
- `lon_min`  out  `MIN_W`  longitude minutes, scaled.
- `cksum_err`  out  1  one-cycle pulse: checksum mismatch, or `*` missing while `CHECK_EN` = 1.
- `fmt_err`  out  1  one-cycle pulse: bad character, overlength line, or field overflow.

Behaviour:
- Reset: on `reset_n` = 0 at a `clk` edge, all outputs go to 0, state goes to IDLE, and the shadow record, counters and XOR accumulator are cleared. Reset applied mid-sentence discards that sentence.
- Bytes are processed only on cycles where `in_valid` = 1; on other cycles all state holds.
- IDLE: wait for `$` (0x24). On `$`: clear the XOR, line count and field index, then go to ADDR.
- ADDR: capture 5 address characters.
  - Characters 3..5 must be `RMC`; characters 1..2 are not checked.
  - The 6th byte must be `,`; then go to FIELD.
  - Any mismatch goes to IDLE silently (other sentence types are not errors).
- FIELD: each `,` increments the field index and finalises the current numeric field.
  - Field 2 (status): `gps_valid` shadow = (byte == `A`).
  - Field 3 (latitude, `ddmm.f…`): 2 degree digits, then 2 minute digits.
  - Field 4: `north` shadow = (byte == `N`).
  - Field 5 (longitude, `dddmm.f…`): 3 degree digits, then 2 minute digits.
  - Field 6: `east` shadow = (byte == `E`).
  - Other fields: contribute to the XOR only.
  - `*` goes to CK_HI.
- Numeric accumulation:
  - Each digit updates value ← value × 10 + digit, computed as shift-add with no multiplier.
  - `.` switches to fractional mode.
  - Fractional digits beyond `FRAC_DIGITS` are ignored (truncated).
  - At field end, minutes are multiplied by 10 once per missing fractional digit (one digit per cycle is allowed; completion is guaranteed before CK_LO finishes).
  - A non-digit other than one `.` raises the sentence-bad flag.
  - Too many integer digits raises the sentence-bad flag.
  - An empty lat/lon field leaves that position unchanged on commit.
- XOR covers every byte strictly between `$` and `*`.
- CK_HI / CK_LO: accept two hex digits, upper or lower case. A non-hex byte sets sentence-bad.
- Terminator after CK_LO, `<CR>` or `<LF>`:
  - Sentence-bad → `fmt_err` pulse.
  - Otherwise, checksum ≠ XOR → `cksum_err` pulse.
  - Otherwise the shadow record is copied to the outputs and `fix_strobe` pulses.
  - Then go to IDLE.
- If `CHECK_EN` = 0, `<CR>` in FIELD commits with the same rules. If `CHECK_EN` = 1, that case gives a `cksum_err` pulse.
- Latency: the commit and all pulses occur in the cycle after the terminator byte is sampled; the outputs are registered.
- Simultaneous events:
  - `$` in any state restarts the sentence without an error pulse, and takes priority over every other rule.
  - Line count reaching `MAX_LINE` without a terminator gives a `fmt_err` pulse and IDLE.
- Outputs change only on commit, never partially; `fix_strobe`, `cksum_err` and `fmt_err` are mutually exclusive.

Decomposition:
- Package `nmea_pkg`:
  - ASCII constants (`$`, `,`, `*`, `.`, CR, LF).
  - Parser state enum (IDLE, ADDR, FIELD, CK_HI, CK_LO).
  - Function `hex_nibble`.
  - Function `is_digit`.
- Sub-module `nmea_num_accum`:
  - Parameterised on integer-digit count, `FRAC_DIGITS` and width.
  - Inputs: clear, digit strobe, dot strobe, finalise.
  - Outputs: degrees, scaled minutes, overflow/bad.
  - Instantiated twice, for latitude and longitude.

Test Plan:
- `$GPRMC,123519,A,4807.038,N,01131.000,E,022.4,084.4,230394,003.1,W*6A<CR><LF>` with `FRAC_DIGITS` = 4 → `fix_strobe`; `gps_valid` = 1, `lat_deg` = 48, `lat_min` = 70380, `north` = 1, `lon_deg` = 11, `lon_min` = 310000, `east` = 1.
- Same sentence with `*6B` → `cksum_err` pulse, no `fix_strobe`, outputs retain the previous values.
- `$GNRMC` sentence with status `V`, `3355.12345,S`, `15112.5,W` and correct checksum → `gps_valid` = 0, `north` = 0, `east` = 0, `lat_min` = 551234 (truncated), `lon_min` = 125000.
- `$GPGGA,…*xx` → no pulse, outputs unchanged. A second `$GPRMC` sentence, cut off by a new `$` mid-field and followed by a full valid sentence → exactly one `fix_strobe`.
- Latitude field `48A7.038` → `fmt_err`. A 90-byte line with no CR → `fmt_err` at byte 82.
- `reset_n` low during field 5 → outputs 0. The next valid sentence commits correctly, with bytes driven back-to-back (`in_valid` = 1 every cycle).
